logo_bounce_ctrl: RTL

Screen-saver motion controller that owns the logo image ROM's address inputs. It keeps the logo's top-left position on a 640x480 raster and moves it diagonally, bouncing off the screen edges, once every FRAME_DIV frames. On every pixel it converts the raster position into ROM-relative x_img/y_img and returns the masked, latency-aligned logo pixel to the video output stage.

---
 rtl/logo_bounce_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/logo_bounce_ctrl.sv
// Bouncing-logo motion controller: moves the logo diagonally once per FRAME_DIV frames and
// turns the raster position into logo ROM addresses, returning the masked pixel two clocks later.
module logo_bounce_ctrl #(
    parameter int unsigned SCREEN_W  = 640,
    parameter int unsigned SCREEN_H  = 480,
    parameter int unsigned IMG_W     = 80,
    parameter int unsigned IMG_H     = 96,
    parameter int unsigned STEP      = 1,
    parameter int unsigned FRAME_DIV = 1,
    parameter int unsigned INIT_X    = 0,
    parameter int unsigned INIT_Y    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] x_px,
    input  logic [9:0] y_px,
    input  logic       activevideo,
    input  logic       frame_tick,
    input  logic       pause,
    output logic [9:0] x_img,
    output logic [9:0] y_img,
    input  logic       pix_in,
    output logic       pixel_out,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic [7:0] bounce_cnt,
    output logic       corner
);

    localparam logic [10:0] LIM_X    = 11'(SCREEN_W - IMG_W);
    localparam logic [10:0] LIM_Y    = 11'(SCREEN_H - IMG_H);
    localparam logic [10:0] STEP11   = 11'(STEP);
    localparam logic [10:0] IMG_W11  = 11'(IMG_W);
    localparam logic [10:0] IMG_H11  = 11'(IMG_H);
    localparam logic [7:0]  DIV_LAST = 8'(FRAME_DIV - 1);

    logic [9:0]  r_pos_x, r_pos_y;
    logic        r_dir_x, r_dir_y;
    logic [7:0]  r_cnt, r_bounce;
    logic        r_corner;
    logic [9:0]  r_x_img, r_y_img;
    logic        r_in_box_d1, r_act_d1, r_in_box_d2, r_act_d2;

    logic        w_tick_ok, w_update;
    logic [7:0]  w_cnt_d;
    logic [10:0] w_sum_x, w_sum_y;
    logic [9:0]  w_pos_x_d, w_pos_y_d;
    logic        w_dir_x_d, w_dir_y_d, w_hit_x, w_hit_y;
    logic [10:0] w_x_end, w_y_end;
    logic        w_in_box;

    // Next position is computed every cycle; it is only committed on an accepted update.
    always_comb begin
        w_tick_ok = frame_tick && !pause;
        w_update  = w_tick_ok && (r_cnt == DIV_LAST);
        w_cnt_d   = r_cnt;
        if (w_tick_ok) begin
            w_cnt_d = (r_cnt == DIV_LAST) ? 8'd0 : r_cnt + 8'd1;
        end

        w_sum_x   = {1'b0, r_pos_x} + STEP11;
        w_pos_x_d = r_pos_x;
        w_dir_x_d = r_dir_x;
        w_hit_x   = 1'b0;
        if (r_dir_x) begin
            if (w_sum_x >= LIM_X) begin
                w_pos_x_d = 10'(LIM_X);
                w_dir_x_d = 1'b0;
                w_hit_x   = 1'b1;
            end else begin
                w_pos_x_d = w_sum_x[9:0];
            end
        end else if ({1'b0, r_pos_x} <= STEP11) begin
            w_pos_x_d = 10'd0;
            w_dir_x_d = 1'b1;
            w_hit_x   = 1'b1;
        end else begin
            w_pos_x_d = r_pos_x - 10'(STEP);
        end

        w_sum_y   = {1'b0, r_pos_y} + STEP11;
        w_pos_y_d = r_pos_y;
        w_dir_y_d = r_dir_y;
        w_hit_y   = 1'b0;
        if (r_dir_y) begin
            if (w_sum_y >= LIM_Y) begin
                w_pos_y_d = 10'(LIM_Y);
                w_dir_y_d = 1'b0;
                w_hit_y   = 1'b1;
            end else begin
                w_pos_y_d = w_sum_y[9:0];
            end
        end else if ({1'b0, r_pos_y} <= STEP11) begin
            w_pos_y_d = 10'd0;
            w_dir_y_d = 1'b1;
            w_hit_y   = 1'b1;
        end else begin
            w_pos_y_d = r_pos_y - 10'(STEP);
        end

        w_x_end  = {1'b0, r_pos_x} + IMG_W11;
        w_y_end  = {1'b0, r_pos_y} + IMG_H11;
        w_in_box = (x_px >= r_pos_x) && ({1'b0, x_px} < w_x_end) &&
                   (y_px >= r_pos_y) && ({1'b0, y_px} < w_y_end);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos_x  <= 10'(INIT_X);
            r_pos_y  <= 10'(INIT_Y);
            r_dir_x  <= 1'b1;
            r_dir_y  <= 1'b1;
            r_cnt    <= 8'd0;
            r_bounce <= 8'd0;
            r_corner <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_d;
            r_corner <= w_update && w_hit_x && w_hit_y;
            if (w_update) begin
                r_pos_x <= w_pos_x_d;
                r_pos_y <= w_pos_y_d;
                r_dir_x <= w_dir_x_d;
                r_dir_y <= w_dir_y_d;
                // A simultaneous hit on both axes still counts as a single bounce.
                if (w_hit_x || w_hit_y) begin
                    r_bounce <= r_bounce + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_img     <= 10'd0;
            r_y_img     <= 10'd0;
            r_in_box_d1 <= 1'b0;
            r_act_d1    <= 1'b0;
            r_in_box_d2 <= 1'b0;
            r_act_d2    <= 1'b0;
        end else begin
            r_x_img     <= x_px - r_pos_x;
            r_y_img     <= y_px - r_pos_y;
            r_in_box_d1 <= w_in_box;
            r_act_d1    <= activevideo;
            r_in_box_d2 <= r_in_box_d1;
            r_act_d2    <= r_act_d1;
        end
    end

    // pix_in is the ROM's registered output, so masking it with the d2 flags gives two clocks.
    assign pixel_out  = pix_in & r_in_box_d2 & r_act_d2;
    assign x_img      = r_x_img;
    assign y_img      = r_y_img;
    assign pos_x      = r_pos_x;
    assign pos_y      = r_pos_y;
    assign dir_x      = r_dir_x;
    assign dir_y      = r_dir_y;
    assign bounce_cnt = r_bounce;
    assign corner     = r_corner;

endmodule
